// File: rtl/operand_skew_feeder_if.sv
// Operand vector handshake bundle for operand_skew_feeder.
// The master drives vectors, and the feeder (slave) returns ready.
interface operand_skew_feeder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DIM        = 4
);
    logic [DIM*DATA_WIDTH-1:0] vec;
    logic                      vec_valid;
    logic                      vec_ready;

    modport master (output vec, output vec_valid, input vec_ready);
    modport slave  (input vec, input vec_valid, output vec_ready);
endinterface

// File: rtl/operand_skew_feeder.sv
// operand_skew_feeder: edge feeder for a systolic MAC array.
// It buffers K operand vectors of DIM lanes each. It then streams them into
// one array edge with a diagonal skew, where lane i lags by i cycles.
// It also drives the shared accumulate-enable line (start_o).
// Build option: define FEEDER_AUTO_CLEAR_EN to make HOLD last only for the
// done_o cycle and then return to IDLE by itself. Without the macro, HOLD
// persists until clear_i is asserted.
module operand_skew_feeder #(
    parameter int DATA_WIDTH = 32,
    parameter int DIM        = 4,
    parameter int K          = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    operand_skew_feeder_if.slave       vec_if,
    input  logic                       go_i,
    input  logic                       clear_i,
    output logic [DIM*DATA_WIDTH-1:0]  lane_o,
    output logic                       start_o,
    output logic                       busy_o,
    output logic                       done_o
);

    // Last feed index, including the drain cycles that let data cross the array.
    localparam int TMAX = K + 2*DIM - 3;
    localparam int TW   = $clog2(TMAX + 2);
    localparam int LDW  = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, LOADED, FEED, HOLD} state_e;

    state_e                    state_q, state_d;
    logic [LDW-1:0]            ld_cnt_q, ld_cnt_d;
    logic [TW-1:0]             t_q, t_d;
    logic [DIM*DATA_WIDTH-1:0] lane_q, lane_d;
    logic                      start_q, start_d;
    logic                      done_q, done_d;
    logic                      load_en;
    logic                      feed_en;
    int                        feed_t;
    logic                      vec_ready;
    logic                      xfer;

    logic [DATA_WIDTH-1:0]     buf_q [K][DIM];

    assign vec_ready        = (state_q == IDLE) || (state_q == LOAD);
    assign vec_if.vec_ready = vec_ready;
    assign xfer             = vec_if.vec_valid && vec_ready;

    assign lane_o  = lane_q;
    assign start_o = start_q;
    assign done_o  = done_q;
    assign busy_o  = (state_q == FEED) || (state_q == HOLD);

    // Next-state, counter and registered-output decode; clear_i overrides all.
    always_comb begin
        state_d  = state_q;
        ld_cnt_d = ld_cnt_q;
        t_d      = t_q;
        lane_d   = '0;
        start_d  = start_q;
        done_d   = 1'b0;
        load_en  = 1'b0;
        feed_en  = 1'b0;
        feed_t   = 0;

        if (clear_i) begin
            state_d  = IDLE;
            ld_cnt_d = '0;
            t_d      = '0;
            start_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE, LOAD: begin
                    if (xfer) begin
                        load_en = 1'b1;
                        if (ld_cnt_q == LDW'(K - 1)) begin
                            state_d  = LOADED;
                            ld_cnt_d = '0;
                        end else begin
                            state_d  = LOAD;
                            ld_cnt_d = ld_cnt_q + LDW'(1);
                        end
                    end
                end
                LOADED: begin
                    if (go_i) begin
                        state_d = FEED;
                        start_d = 1'b1;
                        t_d     = TW'(1);
                        feed_en = 1'b1;
                        feed_t  = 0;
                    end
                end
                FEED: begin
                    if (t_q == TW'(TMAX + 1)) begin
                        state_d = HOLD;
                        done_d  = 1'b1;
                        t_d     = '0;
                    end else begin
                        feed_en = 1'b1;
                        feed_t  = int'(t_q);
                        t_d     = t_q + TW'(1);
                    end
                end
                HOLD: begin
`ifdef FEEDER_AUTO_CLEAR_EN
                    state_d = IDLE;
                    start_d = 1'b0;
`endif
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Lane i shows row (t - i) while that row exists, otherwise zero.
        if (feed_en) begin
            for (int r = 0; r < K; r++) begin
                for (int i = 0; i < DIM; i++) begin
                    if (r + i == feed_t) begin
                        lane_d[i*DATA_WIDTH +: DATA_WIDTH] = buf_q[r][i];
                    end
                end
            end
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            ld_cnt_q <= '0;
            t_q      <= '0;
            lane_q   <= '0;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ld_cnt_q <= ld_cnt_d;
            t_q      <= t_d;
            lane_q   <= lane_d;
            start_q  <= start_d;
            done_q   <= done_d;
        end
    end

    // Operand buffer. Its contents only matter after a full load, so it has no reset.
    always_ff @(posedge clk_i) begin
        if (load_en) begin
            for (int r = 0; r < K; r++) begin
                if (ld_cnt_q == LDW'(r)) begin
                    for (int i = 0; i < DIM; i++) begin
                        buf_q[r][i] <= vec_if.vec[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_operand_skew_feeder.sv
// Self-checking bench for operand_skew_feeder with DATA_WIDTH=8, DIM=2, K=2.
module tb_operand_skew_feeder;

    localparam int DW  = 8;
    localparam int DIM = 2;
    localparam int K   = 2;

    logic              clk;
    logic              rst_n;
    logic              go;
    logic              clear;
    logic [DIM*DW-1:0] lane;
    logic              start;
    logic              busy;
    logic              done;

    operand_skew_feeder_if #(.DATA_WIDTH(DW), .DIM(DIM)) vif ();

    operand_skew_feeder #(.DATA_WIDTH(DW), .DIM(DIM), .K(K)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .vec_if  (vif),
        .go_i    (go),
        .clear_i (clear),
        .lane_o  (lane),
        .start_o (start),
        .busy_o  (busy),
        .done_o  (done)
    );

    // Each record holds two loaded vectors and the lane word for t=0..3 ({lane1,lane0}).
    typedef struct {
        logic [15:0]       v0;
        logic [15:0]       v1;
        logic [3:0][15:0]  lanes;
    } vec_rec_t;

    vec_rec_t    tbl [4];
    logic [15:0] sbQ [$];
    int          vecCount  = 0;
    int          missCount = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] v);
        checkOutput("load_ready", 16'(vif.vec_ready), 16'h1);
        vif.vec       = v;
        vif.vec_valid = 1'b1;
        step();
        vif.vec_valid = 1'b0;
    endtask

    // Launch from LOADED, score the four fed cycles, then check done and HOLD exit.
    task automatic runFeed(input logic [3:0][15:0] exp);
        logic [15:0] e;
        checkOutput("loaded_ready", 16'(vif.vec_ready), 16'h0);
        checkOutput("loaded_busy", 16'(busy), 16'h0);
        go = 1'b1;
        for (int t = 0; t < 4; t++) sbQ.push_back(exp[t]);
        step();
        go = 1'b0;
        for (int t = 0; t < 4; t++) begin
            if (sbQ.size() == 0) begin
                missCount++;
                vecCount++;
                $display("[TB] FAIL scoreboard_empty: got 0 entries expected 1");
            end else begin
                e = sbQ.pop_front();
                checkOutput($sformatf("lane_t%0d", t), lane, e);
            end
            checkOutput("feed_start", 16'(start), 16'h1);
            checkOutput("feed_busy", 16'(busy), 16'h1);
            checkOutput("feed_done", 16'(done), 16'h0);
            step();
        end
        checkOutput("done_pulse", 16'(done), 16'h1);
        checkOutput("done_start", 16'(start), 16'h1);
        checkOutput("done_lane", lane, 16'h0);
        checkOutput("done_busy", 16'(busy), 16'h1);
        step();
`ifdef FEEDER_AUTO_CLEAR_EN
        checkOutput("auto_start", 16'(start), 16'h0);
        checkOutput("auto_busy", 16'(busy), 16'h0);
        checkOutput("auto_done", 16'(done), 16'h0);
        checkOutput("auto_ready", 16'(vif.vec_ready), 16'h1);
`else
        checkOutput("hold_done", 16'(done), 16'h0);
        checkOutput("hold_start", 16'(start), 16'h1);
        checkOutput("hold_lane", lane, 16'h0);
        step();
        step();
        checkOutput("hold_persist", 16'(start), 16'h1);
        checkOutput("hold_busy", 16'(busy), 16'h1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        checkOutput("clr_start", 16'(start), 16'h0);
        checkOutput("clr_busy", 16'(busy), 16'h0);
        checkOutput("clr_lane", lane, 16'h0);
        checkOutput("clr_ready", 16'(vif.vec_ready), 16'h1);
`endif
    endtask

    initial begin
        logic [15:0] bpQ [$];
        int          accepted;
        logic        r;

        tbl[0] = '{v0: 16'h0201, v1: 16'h0403, lanes: {16'h0000, 16'h0400, 16'h0203, 16'h0001}};
        tbl[1] = '{v0: 16'h7F80, v1: 16'h00FF, lanes: {16'h0000, 16'h0000, 16'h7FFF, 16'h0080}};
        tbl[2] = '{v0: 16'h2211, v1: 16'h4433, lanes: {16'h0000, 16'h4400, 16'h2233, 16'h0011}};
        tbl[3] = '{v0: 16'h55AA, v1: 16'hF00F, lanes: {16'h0000, 16'hF000, 16'h550F, 16'h00AA}};

        rst_n         = 1'b0;
        go            = 1'b0;
        clear         = 1'b0;
        vif.vec       = '0;
        vif.vec_valid = 1'b0;
        step();
        step();
        checkOutput("rst_lane", lane, 16'h0);
        checkOutput("rst_start", 16'(start), 16'h0);
        checkOutput("rst_busy", 16'(busy), 16'h0);
        checkOutput("rst_done", 16'(done), 16'h0);
        rst_n = 1'b1;
        step();
        checkOutput("rst_ready", 16'(vif.vec_ready), 16'h1);

        // Table-driven load/feed runs.
        for (int n = 0; n < 4; n++) begin
            applyStimulus(tbl[n].v0);
            applyStimulus(tbl[n].v1);
            runFeed(tbl[n].lanes);
        end

        // Backpressure: three vectors offered back to back, go held during the load.
        bpQ.push_back(16'h0605);
        bpQ.push_back(16'h0807);
        bpQ.push_back(16'h0A09);
        accepted      = 0;
        vif.vec       = bpQ[0];
        vif.vec_valid = 1'b1;
        go            = 1'b1;
        for (int c = 0; c < 5; c++) begin
            r = vif.vec_ready;
            step();
            if (r) begin
                accepted++;
                void'(bpQ.pop_front());
                if (bpQ.size() > 0) vif.vec = bpQ[0];
                if (accepted == 2) go = 1'b0;
            end
        end
        vif.vec_valid = 1'b0;
        go            = 1'b0;
        checkOutput("bp_accepted", 16'(accepted), 16'd2);
        checkOutput("bp_ready", 16'(vif.vec_ready), 16'h0);
        checkOutput("bp_go_ignored", 16'(busy), 16'h0);
        runFeed({16'h0000, 16'h0800, 16'h0607, 16'h0005});

        // A transfer that coincides with clear_i is dropped and the load restarts.
        applyStimulus(16'h3131);
        vif.vec       = 16'h9999;
        vif.vec_valid = 1'b1;
        clear         = 1'b1;
        step();
        clear         = 1'b0;
        vif.vec_valid = 1'b0;
        checkOutput("drop_ready", 16'(vif.vec_ready), 16'h1);
        checkOutput("drop_busy", 16'(busy), 16'h0);
        applyStimulus(16'h0C0B);
        checkOutput("reload_ready", 16'(vif.vec_ready), 16'h1);
        applyStimulus(16'h0E0D);
        runFeed({16'h0000, 16'h0E00, 16'h0C0D, 16'h000B});

        // Asynchronous reset in the middle of a feed.
        applyStimulus(16'h2221);
        applyStimulus(16'h2423);
        go = 1'b1;
        step();
        go = 1'b0;
        step();
        checkOutput("mid_feed_start", 16'(start), 16'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_lane", lane, 16'h0);
        checkOutput("async_start", 16'(start), 16'h0);
        checkOutput("async_busy", 16'(busy), 16'h0);
        #2;
        rst_n = 1'b1;
        step();
        checkOutput("post_rst_ready", 16'(vif.vec_ready), 16'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
